// File: rtl/route4_fifo_pkg.sv
// Shared definitions for the 4-way buffered router: channel encodings,
// default word width and the push-strobe demultiplexor.
package route4_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;
    localparam int NUM_CH    = 4;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    // DMux4Way: steer a single bit onto one of four outputs (bit0=a .. bit3=d).
    function automatic logic [3:0] dmux4way(input logic in_bit, input logic [1:0] sel);
        logic [3:0] out_v;
        out_v = 4'b0000;
        case (sel)
            CH_A:    out_v[0] = in_bit;
            CH_B:    out_v[1] = in_bit;
            CH_C:    out_v[2] = in_bit;
            CH_D:    out_v[3] = in_bit;
            default: out_v = 4'b0000;
        endcase
        return out_v;
    endfunction

endpackage

// File: rtl/route4_fifo_if.sv
// Handshake bundle of the router: one valid/ready input, four valid/ready
// outputs with per-channel head data and full flags.
interface route4_fifo_if
    import route4_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data_a;
    logic [WIDTH-1:0] out_data_b;
    logic [WIDTH-1:0] out_data_c;
    logic [WIDTH-1:0] out_data_d;
    logic [3:0]       full;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data_a, out_data_b, out_data_c, out_data_d, full
    );

    // Router side.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data_a, out_data_b, out_data_c, out_data_d, full
    );
endinterface

// File: rtl/route4_fifo_chan_fifo.sv
// Single-channel FIFO: DEPTH entries, pointer wrap modulo DEPTH, head read
// combinationally from registered storage, no bypass from wdata to rdata.
module route4_fifo_chan_fifo
    import route4_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Guard the strobes so a full channel never overflows and an empty one never underflows.
    always_comb begin
        push_s = push & ~full;
        pop_s  = pop & valid;
    end

    assign valid = (count_r != {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));
    assign rdata = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count; reset clears everything including storage.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/route4_fifo.sv
// Buffered 4-way word router: one input stream demultiplexed by in_sel into
// four independent channel FIFOs, each with its own valid/ready output.
module route4_fifo
    import route4_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clock,
    input  logic         reset_n,
    route4_fifo_if.slave bus
);
    logic [3:0]       full_s;
    logic [3:0]       valid_s;
    logic [3:0]       push_vec_s;
    logic [WIDTH-1:0] rdata_s [NUM_CH];
    logic             sel_full_s;
    logic             in_ready_s;
    logic             push_s;

    // Readiness depends only on the selected channel's fill state, never on out_ready.
    always_comb begin
        sel_full_s = 1'b1;
        case (bus.in_sel)
            CH_A:    sel_full_s = full_s[0];
            CH_B:    sel_full_s = full_s[1];
            CH_C:    sel_full_s = full_s[2];
            CH_D:    sel_full_s = full_s[3];
            default: sel_full_s = 1'b1;
        endcase
        in_ready_s = reset_n & ~sel_full_s;
        push_s     = bus.in_valid & in_ready_s;
        push_vec_s = dmux4way(push_s, bus.in_sel);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        route4_fifo_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .push    (push_vec_s[g]),
            .wdata   (bus.in_data),
            .pop     (bus.out_ready[g]),
            .valid   (valid_s[g]),
            .rdata   (rdata_s[g]),
            .full    (full_s[g])
        );
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = valid_s;
    assign bus.full       = full_s;
    assign bus.out_data_a = rdata_s[0];
    assign bus.out_data_b = rdata_s[1];
    assign bus.out_data_c = rdata_s[2];
    assign bus.out_data_d = rdata_s[3];
endmodule

// File: tb/tb_route4_fifo.sv
// Self-checking bench for route4_fifo: queue-based reference model, one
// per-cycle compare process, directed scenarios with literal expectations,
// then a randomized phase.
module tb_route4_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;
    logic last_acc = 1'b0;

    logic [WIDTH-1:0] q [4][$];

    route4_fifo_if #(.WIDTH(WIDTH)) bus ();

    route4_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_data(input int i);
        case (i)
            0:       return bus.out_data_a;
            1:       return bus.out_data_b;
            2:       return bus.out_data_c;
            default: return bus.out_data_d;
        endcase
    endfunction

    // Reference model: queues per channel, updated from the inputs seen at each edge.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            last_acc = 1'b0;
        end else begin
            logic acc;
            acc = bus.in_valid && (q[bus.in_sel].size() < DEPTH);
            for (int i = 0; i < 4; i++)
                if (q[i].size() > 0 && bus.out_ready[i]) void'(q[i].pop_front());
            if (acc) q[bus.in_sel].push_back(bus.in_data);
            last_acc = acc;
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            logic [3:0] ev;
            logic [3:0] ef;
            for (int i = 0; i < 4; i++) begin
                ev[i] = (q[i].size() != 0);
                ef[i] = (q[i].size() == DEPTH);
                if (ev[i]) check($sformatf("model_data%0d", i), 32'(dut_data(i)), 32'(q[i][0]));
            end
            check("model_out_valid", 32'(bus.out_valid), 32'(ev));
            check("model_full", 32'(bus.full), 32'(ef));
            check("model_in_ready", 32'(bus.in_ready),
                  32'(reset_n && (q[bus.in_sel].size() < DEPTH)));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [1:0] sel, input logic [WIDTH-1:0] data);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic hold;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'b10;
        bus.in_data   = 16'hDEAD;
        bus.out_ready = 4'b0000;

        // 1. Reset held two cycles with a word offered.
        tick();
        tick();
        @(negedge clock);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_data_a", 32'(bus.out_data_a), 32'h0);
        check("rst_data_d", 32'(bus.out_data_d), 32'h0);
        chk_en = 1'b1;
        tick();
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;

        // 2. Route one word to each channel.
        push_word(2'b00, 16'h1111);
        push_word(2'b01, 16'h2222);
        push_word(2'b10, 16'h3333);
        push_word(2'b11, 16'h4444);
        @(negedge clock);
        check("route_valid", 32'(bus.out_valid), 32'hF);
        check("route_a", 32'(bus.out_data_a), 32'h1111);
        check("route_b", 32'(bus.out_data_b), 32'h2222);
        check("route_c", 32'(bus.out_data_c), 32'h3333);
        check("route_d", 32'(bus.out_data_d), 32'h4444);
        tick();
        bus.out_ready = 4'b1111;
        tick();
        bus.out_ready = 4'b0000;

        // 3. Fill channel c.
        push_word(2'b10, 16'hA001);
        push_word(2'b10, 16'hA002);
        @(negedge clock);
        check("fill_full_c", 32'(bus.full), 32'h4);
        bus.in_sel = 2'b10;
        #1;
        check("fill_ready_c", 32'(bus.in_ready), 32'd0);
        bus.in_sel = 2'b00;
        #1;
        check("fill_ready_a", 32'(bus.in_ready), 32'd1);

        // 4. Full channel pops while a push to it is offered.
        bus.in_sel    = 2'b10;
        bus.in_data   = 16'hBEEF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b0100;
        #1;
        check("pop1_c", 32'(bus.out_data_c), 32'hA001);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        @(negedge clock);
        check("pop2_c", 32'(bus.out_data_c), 32'hA002);
        check("after_pop_full", 32'(bus.full), 32'h0);
        check("after_pop_valid", 32'(bus.out_valid), 32'h4);
        check("after_pop_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.out_ready = 4'b1111;
        tick();

        // 5. Streaming round-robin with all consumers ready.
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(k % 4);
            bus.in_data  = 16'hC000 + 16'(k);
            @(negedge clock);
            check("stream_ready", 32'(bus.in_ready), 32'd1);
            if (k > 0) check("stream_data", 32'(dut_data((k - 1) % 4)), 32'hC000 + 32'(k - 1));
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("stream_last", 32'(bus.out_data_d), 32'hC007);
        tick();
        bus.out_ready = 4'b0000;

        // 6. Mid-operation reset with three channels loaded.
        push_word(2'b00, 16'h0A01);
        push_word(2'b01, 16'h0B01);
        push_word(2'b10, 16'h0C01);
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'b11;
        bus.in_data  = 16'h0D01;
        tick();
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("mrst_valid", 32'(bus.out_valid), 32'h0);
        check("mrst_full", 32'(bus.full), 32'h0);
        check("mrst_data_a", 32'(bus.out_data_a), 32'h0);
        check("mrst_data_c", 32'(bus.out_data_c), 32'h0);
        tick();
        push_word(2'b00, 16'h5A5A);
        @(negedge clock);
        check("refill_valid", 32'(bus.out_valid), 32'h1);
        check("refill_a", 32'(bus.out_data_a), 32'h5A5A);
        tick();

        // Randomized phase; an unaccepted offer keeps its sel and data.
        for (int n = 0; n < 3000; n++) begin
            hold = bus.in_valid && !last_acc && reset_n;
            reset_n = ($urandom_range(0, 199) != 0);
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) bus.out_ready = 4'b0000;
            else bus.out_ready = 4'($urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
